// File: rtl/reg_pkg.sv
// Shared types and constants for the one-hot register file and its select encoders.
package reg_pkg;

    localparam int NREGS  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_class;

    // Bit positions within the sticky error vector.
    localparam int ERR_WR = 0;
    localparam int ERR_RD = 1;

endpackage

// File: rtl/onehot_to_index.sv
// Combinational inverse of the 4-to-16 register decode: recovers the index of a
// one-hot select vector and classifies the vector as none, one or multi.
module onehot_to_index
    import reg_pkg::*;
(
    input  logic [NREGS-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output sel_class         cls
);

    logic             seen;
    logic             multi;
    logic [IDX_W-1:0] idx_or;

    always_comb begin
        seen   = 1'b0;
        multi  = 1'b0;
        idx_or = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (vec[i]) begin
                multi  = multi | seen;
                seen   = 1'b1;
                idx_or = idx_or | IDX_W'(i);
            end
        end
    end

    // The OR of set positions is only meaningful for a single set bit; force 0 otherwise.
    always_comb begin
        cls = SEL_NONE;
        idx = '0;
        if (multi) begin
            cls = SEL_MULTI;
        end else if (seen) begin
            cls = SEL_ONE;
            idx = idx_or;
        end
    end

endmodule

// File: rtl/reg_file_onehot.sv
// General-purpose register file addressed by one-hot write/read selects, with a
// registered read port, write-through bypass, R0 base-address masking and sticky errors.
module reg_file_onehot #(
    parameter int DATA_W = reg_pkg::DATA_W,
    parameter int NREGS  = reg_pkg::NREGS    // fixed at 16 by the 4-bit register fields
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [NREGS-1:0]  rin_sel,
    input  logic [NREGS-1:0]  rout_sel,
    input  logic              ba_out,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] bus_out,
    output logic              out_valid,
    output logic [1:0]        err
);

    logic [reg_pkg::IDX_W-1:0] widx;
    logic [reg_pkg::IDX_W-1:0] ridx;
    reg_pkg::sel_class         wr_cls;
    reg_pkg::sel_class         rd_cls;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        err_next;

    onehot_to_index u_wr_enc (
        .vec (rin_sel),
        .idx (widx),
        .cls (wr_cls)
    );

    onehot_to_index u_rd_enc (
        .vec (rout_sel),
        .idx (ridx),
        .cls (rd_cls)
    );

    // A multi-hot write select leaves every register untouched.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_cls == reg_pkg::SEL_ONE) begin
            regs[widx] <= bus_in;
        end
    end

    // R0 masking outranks the bypass so a base-address read is always zero.
    always_comb begin
        rd_data  = '0;
        rd_valid = 1'b0;
        if (rd_cls == reg_pkg::SEL_ONE) begin
            rd_valid = 1'b1;
            if (ridx == '0 && ba_out) begin
                rd_data = '0;
            end else if (wr_cls == reg_pkg::SEL_ONE && widx == ridx) begin
                rd_data = bus_in;
            end else begin
                rd_data = regs[ridx];
            end
        end
    end

    // A fresh violation in the clearing cycle keeps its flag set.
    always_comb begin
        err_next = err_clr ? 2'b00 : err;
        if (wr_cls == reg_pkg::SEL_MULTI) begin
            err_next[reg_pkg::ERR_WR] = 1'b1;
        end
        if (rd_cls == reg_pkg::SEL_MULTI) begin
            err_next[reg_pkg::ERR_RD] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bus_out   <= '0;
            out_valid <= 1'b0;
            err       <= 2'b00;
        end else begin
            bus_out   <= rd_data;
            out_valid <= rd_valid;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_reg_file_onehot.sv
// Bench for reg_file_onehot: directed vector table, async-reset sequence and a
// randomised phase checked against a behavioural model through an expected queue.
module tb_reg_file_onehot;

    logic        clock;
    logic        clear;
    logic [15:0] rin_sel;
    logic [15:0] rout_sel;
    logic        ba_out;
    logic [31:0] bus_in;
    logic        err_clr;
    logic [31:0] bus_out;
    logic        out_valid;
    logic [1:0]  err;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected outputs packed as {bus_out, out_valid, err}.
    logic [34:0] exp_q[$];

    typedef struct {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        ba;
        logic [31:0] data;
        logic        clr;
        logic [31:0] ebus;
        logic        ev;
        logic [1:0]  eerr;
    } vec_t;

    vec_t tbl[18];

    logic [31:0] m_regs [16];
    logic [1:0]  m_err;

    reg_file_onehot dut (
        .clock     (clock),
        .clear     (clear),
        .rin_sel   (rin_sel),
        .rout_sel  (rout_sel),
        .ba_out    (ba_out),
        .bus_in    (bus_in),
        .err_clr   (err_clr),
        .bus_out   (bus_out),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_out(input string name);
        logic [34:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            if ({bus_out, out_valid, err} !== e) begin
                n_miss++;
                $display("FAIL %s: got bus=%h valid=%b err=%b, want bus=%h valid=%b err=%b",
                         name, bus_out, out_valid, err, e[34:3], e[2], e[1:0]);
            end
        end
    endtask

    task automatic step(input logic [15:0] rin, input logic [15:0] rout, input logic ba,
                        input logic [31:0] data, input logic clr, input logic [31:0] ebus,
                        input logic ev, input logic [1:0] eerr, input string name);
        rin_sel  = rin;
        rout_sel = rout;
        ba_out   = ba;
        bus_in   = data;
        err_clr  = clr;
        exp_q.push_back({ebus, ev, eerr});
        @(posedge clock);
        #1;
        check_out(name);
    endtask

    function automatic logic [15:0] gen_sel();
        int mode;
        int a;
        int b;
        logic [15:0] v;
        mode = $urandom_range(0, 5);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        v = '0;
        if (mode == 1) begin
            v[a] = 1'b1;
            v[b] = 1'b1;
        end else if (mode >= 2) begin
            v[a] = 1'b1;
        end
        return v;
    endfunction

    function automatic int pos_of(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    initial begin
        clear    = 1'b0;
        rin_sel  = '0;
        rout_sel = '0;
        ba_out   = 1'b0;
        bus_in   = '0;
        err_clr  = 1'b0;

        //          rin       rout      ba    data            clr   ebus            ev    eerr
        tbl[0]  = '{16'h0008, 16'h0000, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 2'b00};
        tbl[1]  = '{16'h0000, 16'h0008, 1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b1, 2'b00};
        tbl[2]  = '{16'h0020, 16'h0020, 1'b0, 32'h12345678, 1'b0, 32'h12345678, 1'b1, 2'b00};
        tbl[3]  = '{16'h0000, 16'h0020, 1'b0, 32'h00000000, 1'b0, 32'h12345678, 1'b1, 2'b00};
        tbl[4]  = '{16'h0001, 16'h0000, 1'b0, 32'h00000044, 1'b0, 32'h00000000, 1'b0, 2'b00};
        tbl[5]  = '{16'h0000, 16'h0001, 1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 2'b00};
        tbl[6]  = '{16'h0000, 16'h0001, 1'b0, 32'h00000000, 1'b0, 32'h00000044, 1'b1, 2'b00};
        tbl[7]  = '{16'h0003, 16'h0000, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0, 2'b01};
        tbl[8]  = '{16'h0000, 16'h0001, 1'b0, 32'h00000000, 1'b0, 32'h00000044, 1'b1, 2'b01};
        tbl[9]  = '{16'h0000, 16'h0002, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 2'b01};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 2'b00};
        tbl[11] = '{16'h0000, 16'h0300, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 2'b10};
        tbl[12] = '{16'h0000, 16'h0000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 2'b10};
        tbl[13] = '{16'h0003, 16'h0000, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 2'b01};
        tbl[14] = '{16'h0000, 16'h0000, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 2'b00};
        tbl[15] = '{16'h0000, 16'h0008, 1'b1, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b1, 2'b00};
        tbl[16] = '{16'h0001, 16'h0001, 1'b1, 32'h00000077, 1'b0, 32'h00000000, 1'b1, 2'b00};
        tbl[17] = '{16'h0000, 16'h0001, 1'b0, 32'h00000000, 1'b0, 32'h00000077, 1'b1, 2'b00};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back(35'd0);
        check_out("reset_state");
        clear = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rin, tbl[i].rout, tbl[i].ba, tbl[i].data, tbl[i].clr,
                 tbl[i].ebus, tbl[i].ev, tbl[i].eerr, $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges, with a valid read and an error pending.
        step(16'h8000, 16'h0000, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 2'b00, "wr_r15");
        step(16'h0003, 16'h8000, 1'b0, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1, 2'b01, "rd_r15");
        rin_sel  = '0;
        rout_sel = '0;
        #3;
        clear = 1'b0;
        #1;
        exp_q.push_back(35'd0);
        check_out("async_reset");
        #2;
        clear = 1'b1;
        step(16'h0000, 16'h8000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b00, "r15_after_reset");
        step(16'h0000, 16'h0008, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b00, "r3_after_reset");

        // Randomised traffic against a behavioural model starting from reset contents.
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_err = 2'b00;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] rin;
            logic [15:0] rout;
            logic        ba;
            logic        clr;
            logic [31:0] data;
            logic [31:0] ebus;
            logic        ev;
            logic [1:0]  eerr;
            int          wc;
            int          rc;
            int          wi;
            int          ri;
            rin  = gen_sel();
            rout = gen_sel();
            ba   = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            data = $urandom;
            if ($urandom_range(0, 4) == 0) rout = rin;
            wc = $countones(rin);
            rc = $countones(rout);
            wi = pos_of(rin);
            ri = pos_of(rout);
            ev   = (rc == 1);
            ebus = '0;
            if (rc == 1) begin
                if (ri == 0 && ba) ebus = '0;
                else if (wc == 1 && wi == ri) ebus = data;
                else ebus = m_regs[ri];
            end
            eerr = (clr ? 2'b00 : m_err) | {rc > 1, wc > 1};
            step(rin, rout, ba, data, clr, ebus, ev, eerr, $sformatf("rand%0d", n));
            if (wc == 1) m_regs[wi] = data;
            m_err = eerr;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_file_onehot.md
Name: reg_file_onehot

Overview:
- General-purpose register file at the consuming end of the register select/encode stage.
- Takes the 16-bit one-hot write-enable (Rin) and read-enable (Rout) vectors produced by the select/encode stage and encodes each back to a 4-bit register index.
- Writes the datapath bus into the selected register and drives the selected register back onto the bus.
- Honours base-address semantics, where R0 reads as zero when ba_out is asserted, and flags illegal multi-hot select vectors.

Parameters:
- DATA_W, 32, register and bus width.
- NREGS, 16, number of registers; fixed at 16 to match the 4-bit register fields.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- rin_sel  input  16  one-hot write select (RinOut of the select/encode stage).
- rout_sel  input  16  one-hot read select (RoutOut of the select/encode stage).
- ba_out  input  1  base-address read qualifier; forces a read of R0 to zero.
- bus_in  input  DATA_W  write data from the datapath bus.
- err_clr  input  1  synchronous clear of the sticky error flags.
- bus_out  output  DATA_W  registered read data.
- out_valid  output  1  bus_out holds valid read data this cycle.
- err  output  2  sticky error flags; bit0 = multi-hot rin_sel, bit1 = multi-hot rout_sel.

Behaviour:
- Reset (clear=0, asynchronous):
  - All registers, bus_out, out_valid and err go to 0.
  - Reset takes effect mid-operation; any write or read in flight is dropped.
- Encoding:
  - Each select vector is classified as none (all zero), one (exactly one bit set) or multi (two or more bits set).
  - For a one vector, idx is the position of the set bit.
- Write:
  - Rising edge with rin_sel = one: reg[widx] <= bus_in.
  - rin_sel = none: no write.
  - rin_sel = multi: no register changes, and err[0] <= 1.
  - R0 is a real, writable register.
- Read (latency 1 cycle):
  - Rising edge with rout_sel = one: out_valid <= 1.
    - bus_out <= 0 if ridx==0 and ba_out=1.
    - Otherwise bus_out <= bus_in if rin_sel is one and widx==ridx (write-through bypass).
    - Otherwise bus_out <= reg[ridx].
  - rout_sel = none or multi: out_valid <= 0 and bus_out <= 0, so the bus reads zero when not driven.
  - rout_sel = multi also sets err[1] <= 1.
- ba_out when rout_sel does not select R0: no effect.
- Simultaneous write and read of the same register: the write commits, and bus_out shows the new value (bypass). ba_out masking of R0 takes priority over the bypass.
- Errors:
  - Sticky; cleared only by err_clr=1 at a rising edge or by reset.
  - If err_clr and a new violation occur in the same cycle, the new violation wins (flag ends at 1).
- Back-to-back reads on consecutive cycles yield a new bus_out every cycle, giving full throughput.
- No X propagation: unused index paths and default branches drive 0.

Decomposition:
- Shared package reg_pkg holds:
  - NREGS=16, IDX_W=4, DATA_W=32
  - sel_class enum {SEL_NONE, SEL_ONE, SEL_MULTI}
  - ERR_WR=0, ERR_RD=1 bit positions
- One sub-module, onehot_to_index, instantiated twice (write and read sides):
  - Input: 16-bit vector.
  - Outputs: 4-bit idx and the sel_class.
  - Purely combinational; it is the inverse of the 4-to-16 decode.

Test Plan:
1. Reset, then write: clear=0→1; rin_sel=16'h0008, bus_in=32'hDEADBEEF; next cycle rout_sel=16'h0008 → one cycle later bus_out=32'hDEADBEEF, out_valid=1, err=0.
2. Bypass: rin_sel=rout_sel=16'h0020 with bus_in=32'h12345678 in the same cycle → next cycle bus_out=32'h12345678; a later read of R5 also returns 32'h12345678.
3. Base-address mask: write R0=32'h00000044, then rout_sel=16'h0001 with ba_out=1 → bus_out=0, out_valid=1; repeat with ba_out=0 → bus_out=32'h00000044.
4. Multi-hot write: rin_sel=16'h0003, bus_in=32'hFFFFFFFF → R0 and R1 unchanged on readback, err=2'b01, and err stays set until err_clr pulses (then err=0).
5. Multi-hot and idle read: rout_sel=16'h0300 → out_valid=0, bus_out=0, err[1]=1; rout_sel=0 → out_valid=0, bus_out=0, err unchanged.
6. Async reset mid-operation: after writing R15=32'hA5A5A5A5, drop clear between clock edges → bus_out, out_valid and err go to 0 immediately; after release, reading R15 returns 0.
